// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath widths, ALU opcodes and the
// operand forward-select encoding used by the EX operand stage.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRA  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001,
        ALU_BEQ  = 4'b1010,
        ALU_BNE  = 4'b1011,
        ALU_BLT  = 4'b1100,
        ALU_BGE  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand source select: x0 / MEM / WB / held data, plus the stall and
// WB-refresh match terms. Forwarding paths exist only with EX_OPERAND_FWD_EN.
module fwd_mux #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RA_W = riscv_pkg::RA_W
) (
    input  logic [RA_W-1:0] src_addr,
    input  logic [XLEN-1:0] held_data,
    input  logic            used,
    input  logic            mem_reg_wr,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            mem_is_load,
    input  logic            wb_reg_wr,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd_data,
    output logic            stall,
    output logic            refresh
);
    import riscv_pkg::*;

    fwd_sel_t sel;
    logic     is_zero, mem_hit, wb_hit;

    assign is_zero = (src_addr == '0);
    assign mem_hit = mem_reg_wr && (mem_rd == src_addr) && !is_zero;
    assign wb_hit  = wb_reg_wr && (wb_rd == src_addr) && !is_zero;
    // A WB write to this source lands in the held copy on the next edge.
    assign refresh = wb_hit;

`ifdef EX_OPERAND_FWD_EN
    always_comb begin
        sel = FWD_NONE;
        if (is_zero)                      sel = FWD_ZERO;
        else if (mem_hit && !mem_is_load) sel = FWD_MEM;
        else if (wb_hit)                  sel = FWD_WB;
    end
    assign stall = used && mem_hit && mem_is_load;
`else
    logic unused_load;
    assign unused_load = mem_is_load;
    always_comb begin
        sel = is_zero ? FWD_ZERO : FWD_NONE;
    end
    // Without bypass paths, wait until every in-flight write has been refreshed.
    assign stall = used && (mem_hit || wb_hit);
`endif

    always_comb begin
        case (sel)
            FWD_ZERO: fwd_data = '0;
            FWD_MEM:  fwd_data = mem_result;
            FWD_WB:   fwd_data = wb_result;
            default:  fwd_data = held_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register and ALU operand select with RAW hazard handling.
// Define EX_OPERAND_FWD_EN for MEM/WB forwarding; otherwise hazards stall.
module ex_operand_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RA_W = riscv_pkg::RA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_wr,
    input  logic [3:0]      id_alu_op,
    input  logic            id_src_a_pc,
    input  logic            id_src_b_imm,
    input  logic            flush,
    input  logic            mem_reg_wr,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            mem_is_load,
    input  logic            wb_reg_wr,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_result,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] data_one,
    output logic [XLEN-1:0] data_two,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_wr
);
    import riscv_pkg::*;

    logic            held_valid, reg_wr_q, src_a_pc_q, src_b_imm_q;
    logic [XLEN-1:0] pc_q, imm_q, rs1_data_q, rs2_data_q;
    logic [RA_W-1:0] rs1_addr_q, rs2_addr_q, rd_q;
    logic [3:0]      alu_op_q;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            stall_rs1, stall_rs2, refresh_rs1, refresh_rs2;
    logic            hazard, capture;

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .src_addr(rs1_addr_q), .held_data(rs1_data_q), .used(!src_a_pc_q),
        .mem_reg_wr(mem_reg_wr), .mem_rd(mem_rd), .mem_result(mem_result),
        .mem_is_load(mem_is_load), .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd),
        .wb_result(wb_result), .fwd_data(fwd_rs1), .stall(stall_rs1),
        .refresh(refresh_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .src_addr(rs2_addr_q), .held_data(rs2_data_q), .used(!src_b_imm_q),
        .mem_reg_wr(mem_reg_wr), .mem_rd(mem_rd), .mem_result(mem_result),
        .mem_is_load(mem_is_load), .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd),
        .wb_result(wb_result), .fwd_data(fwd_rs2), .stall(stall_rs2),
        .refresh(refresh_rs2)
    );

    assign hazard   = stall_rs1 || stall_rs2;
    assign ex_valid = held_valid && !hazard;
    // flush frees the slot so the redirect target can enter on the same edge.
    assign id_ready = !held_valid || (ex_ready && !hazard) || flush;
    assign capture  = id_valid && id_ready;

    assign data_one   = src_a_pc_q  ? pc_q  : fwd_rs1;
    assign data_two   = src_b_imm_q ? imm_q : fwd_rs2;
    assign ex_rs2_val = fwd_rs2;
    assign alu_op     = alu_op_q;
    assign ex_pc      = pc_q;
    assign ex_rd      = rd_q;
    assign ex_reg_wr  = reg_wr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid  <= 1'b0;
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            reg_wr_q    <= 1'b0;
            alu_op_q    <= ALU_ADD;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
        end else if (capture) begin
            held_valid  <= 1'b1;
            pc_q        <= id_pc;
            rs1_addr_q  <= id_rs1_addr;
            rs2_addr_q  <= id_rs2_addr;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rd_q        <= id_rd;
            reg_wr_q    <= id_reg_wr;
            alu_op_q    <= id_alu_op;
            src_a_pc_q  <= id_src_a_pc;
            src_b_imm_q <= id_src_b_imm;
        end else begin
            if (flush || (ex_valid && ex_ready)) held_valid <= 1'b0;
            if (flush)       reg_wr_q   <= 1'b0;
            if (refresh_rs1) rs1_data_q <= wb_result;
            if (refresh_rs2) rs2_data_q <= wb_result;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized + directed bench for ex_operand_stage: a reference model predicts
// each retirement into a scoreboard queue, a monitor pops on every DUT retire.
module tb_ex_operand_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd;
    logic        id_reg_wr, id_src_a_pc, id_src_b_imm, flush;
    logic [3:0]  id_alu_op;
    logic        mem_reg_wr, mem_is_load, wb_reg_wr, ex_ready;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_reg_wr;
    logic [31:0] data_one, data_two, ex_rs2_val, ex_pc;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_alu_op(id_alu_op),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm), .flush(flush),
        .mem_reg_wr(mem_reg_wr), .mem_rd(mem_rd), .mem_result(mem_result),
        .mem_is_load(mem_is_load), .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd),
        .wb_result(wb_result), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .data_one(data_one), .data_two(data_two), .alu_op(alu_op),
        .ex_rs2_val(ex_rs2_val), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr)
    );

    typedef struct {
        logic [31:0] d1, d2, rs2v, pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the instruction currently parked in the stage.
    logic        m_valid, m_apc, m_bimm, m_wr, m_cap, m_fire;
    logic [31:0] m_pc, m_imm, m_d1, m_d2;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_op;
    logic        exp_ex_valid, exp_id_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value an operand register would read right now, per the forwarding rules.
    function automatic logic [31:0] opnd(input logic [4:0] rs, input logic [31:0] d);
        if (rs == 5'd0) return 32'd0;
`ifdef EX_OPERAND_FWD_EN
        if (mem_reg_wr && !mem_is_load && mem_rd == rs) return mem_result;
        if (wb_reg_wr && wb_rd == rs) return wb_result;
`endif
        return d;
    endfunction

    function automatic logic blocked(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 1'b0;
`ifdef EX_OPERAND_FWD_EN
        return mem_reg_wr && mem_is_load && mem_rd == rs;
`else
        return (mem_reg_wr && mem_rd == rs) || (wb_reg_wr && wb_rd == rs);
`endif
    endfunction

    task automatic model_clear();
        m_valid = 0; m_apc = 0; m_bimm = 0; m_wr = 0; m_cap = 0; m_fire = 0;
        m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0;
    endtask

    task automatic predict();
        logic hz;
        exp_t e;
        if (!rst_n) model_clear();
        hz = m_valid && (blocked(m_rs1, !m_apc) || blocked(m_rs2, !m_bimm));
        exp_ex_valid = m_valid && !hz;
        exp_id_ready = !m_valid || (ex_ready && !hz) || flush;
        m_fire = exp_ex_valid && ex_ready;
        m_cap  = rst_n && id_valid && exp_id_ready;
        if (m_fire) begin
            e.d1   = m_apc  ? m_pc  : opnd(m_rs1, m_d1);
            e.d2   = m_bimm ? m_imm : opnd(m_rs2, m_d2);
            e.rs2v = opnd(m_rs2, m_d2);
            e.pc = m_pc; e.op = m_op; e.rd = m_rd; e.wr = m_wr;
            sbq.push_back(e);
        end
    endtask

    task automatic update();
        if (!rst_n) model_clear();
        else if (m_cap) begin
            m_valid = 1; m_pc = id_pc; m_rs1 = id_rs1_addr; m_rs2 = id_rs2_addr;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_rd = id_rd;
            m_wr = id_reg_wr; m_op = id_alu_op; m_apc = id_src_a_pc; m_bimm = id_src_b_imm;
        end else begin
            if (flush || m_fire) m_valid = 0;
            if (flush) m_wr = 0;
            if (wb_reg_wr && wb_rd != 0 && wb_rd == m_rs1) m_d1 = wb_result;
            if (wb_reg_wr && wb_rd != 0 && wb_rd == m_rs2) m_d2 = wb_result;
        end
    endtask

    task automatic step();
        #1 predict();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        mem_reg_wr = 0; mem_rd = 0; mem_result = 0; mem_is_load = 0;
        wb_reg_wr = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [3:0] op, input logic apc,
                         input logic bimm);
        id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_rd = rd;
        id_reg_wr = 1; id_alu_op = op; id_src_a_pc = apc; id_src_b_imm = bimm;
    endtask

    task automatic drain();
        id_valid = 0; flush = 0; ex_ready = 1; idle_bus();
        repeat (3) step();
    endtask

    // Monitor: per-cycle handshake check plus scoreboard pop on each retire.
    initial forever begin
        @(negedge clk);
        #4;
        chk("ex_valid", 32'(ex_valid), 32'(exp_ex_valid));
        chk("id_ready", 32'(id_ready), 32'(exp_id_ready));
        if (ex_valid && ex_ready) begin
            if (sbq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_unexpected: DUT retired pc %h, expected no retire", ex_pc);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_data_one", data_one, mon_e.d1);
                chk("sb_data_two", data_two, mon_e.d2);
                chk("sb_rs2_val", ex_rs2_val, mon_e.rs2v);
                chk("sb_pc", ex_pc, mon_e.pc);
                chk("sb_alu_op", 32'(alu_op), 32'(mon_e.op));
                chk("sb_rd", 32'(ex_rd), 32'(mon_e.rd));
                chk("sb_reg_wr", 32'(ex_reg_wr), 32'(mon_e.wr));
            end
        end
    end

    initial begin
        rst_n = 0; flush = 0; ex_ready = 0; idle_bus();
        issue(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 4'd0, 0, 0);
        id_valid = 0;
        exp_ex_valid = 0; exp_id_ready = 1;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_data_one", data_one, 0);
        chk("rst_data_two", data_two, 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_rs2_val", ex_rs2_val, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_rd", 32'(ex_rd), 0);
        chk("rst_reg_wr", 32'(ex_reg_wr), 0);
        rst_n = 1;
        step();

        // ADD x3,x1,x2
        ex_ready = 1; idle_bus();
        issue(32'h10, 5'd1, 5'd2, 32'd10, 32'd5, 32'd0, 5'd3, ALU_ADD, 0, 0);
        step(); id_valid = 0;
        #1;
        chk("add_ex_valid", 32'(ex_valid), 1);
        chk("add_data_one", data_one, 10);
        chk("add_data_two", data_two, 5);
        chk("add_alu_op", 32'(alu_op), 0);
        step(); drain();

        // MEM (non-load) and WB both write x1
        issue(32'h20, 5'd1, 5'd0, 32'h1, 32'd0, 32'd0, 5'd5, ALU_ADD, 0, 1);
        step(); id_valid = 0;
        mem_reg_wr = 1; mem_rd = 5'd1; mem_result = 32'h20;
        wb_reg_wr = 1; wb_rd = 5'd1; wb_result = 32'h99;
        #1;
`ifdef EX_OPERAND_FWD_EN
        chk("mem_over_wb", data_one, 32'h20);
        chk("mem_over_wb_valid", 32'(ex_valid), 1);
        step();
`else
        chk("nofwd_mem_stall", 32'(ex_valid), 0);
        step(); idle_bus();
        #1;
        chk("nofwd_refreshed", data_one, 32'h99);
        chk("nofwd_release", 32'(ex_valid), 1);
        step();
`endif
        drain();

        // load-use: ld x2 in MEM, ADDI x4,x2,7 held
        issue(32'h30, 5'd2, 5'd0, 32'd0, 32'd0, 32'd7, 5'd4, ALU_ADD, 0, 1);
        step(); id_valid = 0;
        mem_reg_wr = 1; mem_rd = 5'd2; mem_is_load = 1; mem_result = 32'hdead;
        #1;
        chk("ldu_stall_valid", 32'(ex_valid), 0);
        chk("ldu_stall_ready", 32'(id_ready), 0);
        step(); idle_bus();
        wb_reg_wr = 1; wb_rd = 5'd2; wb_result = 32'h40;
`ifndef EX_OPERAND_FWD_EN
        step(); idle_bus();
`endif
        #1;
        chk("ldu_data_one", data_one, 32'h40);
        chk("ldu_data_two", data_two, 7);
        chk("ldu_valid", 32'(ex_valid), 1);
        step(); drain();

        // WB refresh while back-pressured
        issue(32'h40, 5'd1, 5'd0, 32'h11, 32'd0, 32'd0, 5'd6, ALU_OR, 0, 1);
        step(); id_valid = 0; ex_ready = 0;
        step();
        wb_reg_wr = 1; wb_rd = 5'd1; wb_result = 32'h55;
        step(); idle_bus();
        step(); ex_ready = 1;
        #1;
        chk("refresh_data_one", data_one, 32'h55);
        chk("refresh_valid", 32'(ex_valid), 1);
        step(); drain();

        // x0 source ignores MEM rd=0; BEQ selects PC for operand A
        issue(32'h50, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0, 5'd7, ALU_ADD, 0, 1);
        step(); id_valid = 0;
        mem_reg_wr = 1; mem_rd = 5'd0; mem_result = 32'hffff;
        #1;
        chk("x0_data_one", data_one, 0);
        step(); idle_bus();
        issue(32'h100, 5'd3, 5'd4, 32'd1, 32'd2, 32'd8, 5'd0, ALU_BEQ, 1, 0);
        step(); id_valid = 0;
        #1;
        chk("beq_data_one", data_one, 32'h100);
        chk("beq_alu_op", 32'(alu_op), 32'ha);
        step(); drain();

        // flush of a stalled entry together with a new capture
        issue(32'h60, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 5'd8, ALU_SUB, 0, 0);
        step(); id_valid = 0; ex_ready = 0;
        step();
        flush = 1;
        issue(32'h70, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 5'd9, ALU_XOR, 0, 0);
        step(); flush = 0; id_valid = 0; ex_ready = 1;
        #1;
        chk("flush_new_valid", 32'(ex_valid), 1);
        chk("flush_new_pc", ex_pc, 32'h70);
        chk("flush_new_rd", 32'(ex_rd), 9);
        step();
        // flush with nothing behind it
        issue(32'h80, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 5'd10, ALU_AND, 0, 0);
        step(); id_valid = 0; ex_ready = 0; flush = 1;
        step(); flush = 0;
        #1;
        chk("flush_empty_valid", 32'(ex_valid), 0);
        chk("flush_reg_wr", 32'(ex_reg_wr), 0);
        step(); drain();

        // reset asserted in the middle of a stall
        issue(32'h90, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 5'd11, ALU_SLT, 0, 0);
        step(); id_valid = 0; ex_ready = 0;
        step();
        rst_n = 0;
        #1;
        chk("async_rst_valid", 32'(ex_valid), 0);
        step(); rst_n = 1; ex_ready = 1;
        #1;
        chk("post_rst_valid", 32'(ex_valid), 0);
        step(); drain();

        // randomized traffic over a small register window to force matches
        for (int i = 0; i < 3000; i++) begin
            id_valid     = ($urandom_range(0, 9) < 6);
            id_pc        = $urandom;
            id_rs1_addr  = 5'($urandom_range(0, 7));
            id_rs2_addr  = 5'($urandom_range(0, 7));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_rd        = 5'($urandom_range(0, 31));
            id_reg_wr    = $urandom_range(0, 1) == 1;
            id_alu_op    = 4'($urandom_range(0, 13));
            id_src_a_pc  = ($urandom_range(0, 4) == 0);
            id_src_b_imm = ($urandom_range(0, 2) == 0);
            ex_ready     = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 11) == 0);
            mem_reg_wr   = $urandom_range(0, 1) == 1;
            mem_rd       = 5'($urandom_range(0, 7));
            mem_result   = $urandom;
            mem_is_load  = ($urandom_range(0, 2) == 0);
            wb_reg_wr    = $urandom_range(0, 1) == 1;
            wb_rd        = 5'($urandom_range(0, 7));
            wb_result    = $urandom;
            step();
        end
        drain();
        step();
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
